// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receiver.
// Build option: UART_FRAME_CHECKSUM_EN adds the S_CHECK state (trailing XOR checksum byte).
package uart_frame_pkg;

    // Receiver FSM states; S_CHECK only exists when the checksum byte is part of the frame.
    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3
`ifdef UART_FRAME_CHECKSUM_EN
        ,
        S_CHECK   = 3'd4
`endif
    } state_t;

    // Cause reported on err_code alongside a frame_error pulse.
    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_UART    = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: reloads on every kick and counts down while enabled.
// Outside the frame (enable low) it parks at zero so expired cannot assert.
module uart_frame_timeout #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd260000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    logic [23:0] count;

    // Countdown register: kick wins, otherwise decrement toward zero while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 24'd0;
        end else if (kick) begin
            count <= TIMEOUT_CYCLES;
        end else if (!enable) begin
            count <= 24'd0;
        end else if (count != 24'd0) begin
            count <= count - 24'd1;
        end else begin
            count <= count;
        end
    end

    assign expired = enable && (count == 24'd0);

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser for bytes from a UART receiver:
//   SYNC_BYTE, cmd, len, len payload bytes [, XOR checksum].
// Build option: UART_FRAME_CHECKSUM_EN enables the trailing checksum byte.
// Good frames pulse frame_valid one cycle after their last byte; discarded
// frames pulse frame_error with a cause in err_code and leave frame_* untouched.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int          MAX_PAYLOAD    = 8,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd260000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     received,
    input  logic [7:0]               rx_byte,
    input  logic                     recv_error,
    output logic                     frame_valid,
    output logic [7:0]               frame_cmd,
    output logic [3:0]               frame_len,
    output logic [MAX_PAYLOAD*8-1:0] frame_payload,
    output logic                     frame_error,
    output logic [1:0]               err_code,
    output logic                     busy
);

    state_t                   state;
    logic [7:0]               cmd_r;
    logic [3:0]               len_r;
    logic [3:0]               idx_r;
    logic [MAX_PAYLOAD*8-1:0] payload_r;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]               csum_r;
`endif

    logic [MAX_PAYLOAD*8-1:0] payload_next_s;
    logic [MAX_PAYLOAD*8-1:0] payload_masked_s;
    logic                     timeout_s;

    uart_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (state != S_SYNC),
        .kick    (received),
        .expired (timeout_s)
    );

    // Working payload with the current byte merged in, and the copy with bytes at index >= len zeroed.
    always_comb begin
        payload_next_s = payload_r;
        if (idx_r < 4'(MAX_PAYLOAD)) begin
            payload_next_s[{idx_r, 3'b000} +: 8] = rx_byte;
        end else begin
            payload_next_s = payload_r;
        end
        payload_masked_s = '0;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (i < int'(len_r)) begin
                payload_masked_s[i*8 +: 8] = payload_next_s[i*8 +: 8];
            end else begin
                payload_masked_s[i*8 +: 8] = 8'h00;
            end
        end
    end

    // Frame FSM with registered strobes; UART error beats a byte, a byte beats a timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_SYNC;
            cmd_r         <= 8'h00;
            len_r         <= 4'd0;
            idx_r         <= 4'd0;
            payload_r     <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_r        <= 8'h00;
`endif
            frame_valid   <= 1'b0;
            frame_error   <= 1'b0;
            frame_cmd     <= 8'h00;
            frame_len     <= 4'd0;
            frame_payload <= '0;
            err_code      <= 2'd0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            if (recv_error && (state != S_SYNC)) begin
                frame_error <= 1'b1;
                err_code    <= ERR_UART;
                state       <= S_SYNC;
            end else if (received) begin
                case (state)
                    S_SYNC: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state     <= S_CMD;
                            payload_r <= '0;
                            idx_r     <= 4'd0;
`ifdef UART_FRAME_CHECKSUM_EN
                            csum_r    <= 8'h00;
`endif
                        end else begin
                            state <= S_SYNC;
                        end
                    end
                    S_CMD: begin
                        cmd_r  <= rx_byte;
`ifdef UART_FRAME_CHECKSUM_EN
                        csum_r <= csum_r ^ rx_byte;
`endif
                        state  <= S_LEN;
                    end
                    S_LEN: begin
                        len_r  <= rx_byte[3:0];
                        idx_r  <= 4'd0;
`ifdef UART_FRAME_CHECKSUM_EN
                        csum_r <= csum_r ^ rx_byte;
`endif
                        if (rx_byte > 8'(MAX_PAYLOAD)) begin
                            frame_error <= 1'b1;
                            err_code    <= ERR_LEN;
                            state       <= S_SYNC;
                        end else if (rx_byte == 8'h00) begin
`ifdef UART_FRAME_CHECKSUM_EN
                            state <= S_CHECK;
`else
                            frame_valid   <= 1'b1;
                            frame_cmd     <= cmd_r;
                            frame_len     <= 4'd0;
                            frame_payload <= '0;
                            state         <= S_SYNC;
`endif
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        payload_r <= payload_next_s;
                        idx_r     <= idx_r + 4'd1;
`ifdef UART_FRAME_CHECKSUM_EN
                        csum_r    <= csum_r ^ rx_byte;
`endif
                        if (idx_r == (len_r - 4'd1)) begin
`ifdef UART_FRAME_CHECKSUM_EN
                            state <= S_CHECK;
`else
                            frame_valid   <= 1'b1;
                            frame_cmd     <= cmd_r;
                            frame_len     <= len_r;
                            frame_payload <= payload_masked_s;
                            state         <= S_SYNC;
`endif
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
`ifdef UART_FRAME_CHECKSUM_EN
                    S_CHECK: begin
                        if (rx_byte == csum_r) begin
                            frame_valid   <= 1'b1;
                            frame_cmd     <= cmd_r;
                            frame_len     <= len_r;
                            frame_payload <= payload_masked_s;
                        end else begin
                            frame_error <= 1'b1;
                            err_code    <= ERR_CSUM;
                        end
                        state <= S_SYNC;
                    end
`endif
                    default: begin
                        state <= S_SYNC;
                    end
                endcase
            end else if (timeout_s) begin
                frame_error <= 1'b1;
                err_code    <= ERR_TIMEOUT;
                state       <= S_SYNC;
            end else begin
                state <= state;
            end
        end
    end

    assign busy = (state != S_SYNC);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed self-checking bench for uart_frame_rx. Expected frame_valid /
// frame_error events are queued as stimulus is driven and checked by a
// negedge monitor as the DUT pulses. Honours UART_FRAME_CHECKSUM_EN.
module tb_uart_frame_rx;

    localparam int          MAXP = 8;
    localparam logic [23:0] TMO  = 24'd40;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            received = 1'b0;
    logic [7:0]      rx_byte = 8'h00;
    logic            recv_error = 1'b0;
    logic            frame_valid;
    logic [7:0]      frame_cmd;
    logic [3:0]      frame_len;
    logic [MAXP*8-1:0] frame_payload;
    logic            frame_error;
    logic [1:0]      err_code;
    logic            busy;

    typedef struct {
        logic        is_valid;
        logic [1:0]  code;
        logic [7:0]  cmd;
        logic [3:0]  len;
        logic [63:0] payload;
    } event_t;

    event_t sb[$];
    int errors = 0;
    int checks = 0;

    // Model of the held frame_* outputs.
    logic [7:0]  held_cmd = 8'h00;
    logic [3:0]  held_len = 4'd0;
    logic [63:0] held_pl  = 64'd0;

    uart_frame_rx #(
        .MAX_PAYLOAD    (MAXP),
        .SYNC_BYTE      (8'hAA),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .received      (received),
        .rx_byte       (rx_byte),
        .recv_error    (recv_error),
        .frame_valid   (frame_valid),
        .frame_cmd     (frame_cmd),
        .frame_len     (frame_len),
        .frame_payload (frame_payload),
        .frame_error   (frame_error),
        .err_code      (err_code),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        event_t e;
        if (!rst && (frame_valid || frame_error)) begin
            chk("exclusive_strobes", 64'(frame_valid & frame_error), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {62'd0, frame_valid, frame_error}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("event_kind", 64'(frame_valid), 64'(e.is_valid));
                if (!e.is_valid) chk("err_code", 64'(err_code), 64'(e.code));
                chk("frame_cmd", 64'(frame_cmd), 64'(e.cmd));
                chk("frame_len", 64'(frame_len), 64'(e.len));
                chk("frame_payload", frame_payload, e.payload);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        received = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        received = 1'b0;
    endtask

    task automatic expect_error(input logic [1:0] code);
        event_t e;
        e.is_valid = 1'b0; e.code = code;
        e.cmd = held_cmd; e.len = held_len; e.payload = held_pl;
        sb.push_back(e);
    endtask

    // Sends a complete good frame; payload bytes are taken from pl[len*8-1:0].
    task automatic send_good(input logic [7:0] cmd, input logic [3:0] len, input logic [63:0] pl);
        event_t e;
        logic [7:0] cs;
        logic [63:0] masked;
        masked = 64'd0;
        for (int i = 0; i < int'(len); i++) masked[i*8 +: 8] = pl[i*8 +: 8];
        held_cmd = cmd; held_len = len; held_pl = masked;
        e.is_valid = 1'b1; e.code = 2'd0;
        e.cmd = cmd; e.len = len; e.payload = masked;
        sb.push_back(e);
        cs = cmd ^ {4'd0, len};
        send_byte(8'hAA);
        send_byte(cmd);
        send_byte({4'd0, len});
        for (int i = 0; i < int'(len); i++) begin
            cs = cs ^ masked[i*8 +: 8];
            send_byte(masked[i*8 +: 8]);
        end
`ifdef UART_FRAME_CHECKSUM_EN
        send_byte(cs);
`endif
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(frame_valid), 64'd0);
        chk("reset_error", 64'(frame_error), 64'd0);
        chk("reset_cmd", 64'(frame_cmd), 64'd0);
        chk("reset_len", 64'(frame_len), 64'd0);
        chk("reset_payload", frame_payload, 64'd0);
        chk("reset_err_code", 64'(err_code), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        // Basic good frame.
        send_good(8'h10, 4'd2, 64'h6655);
        drain(10);
        chk("busy_after_good", 64'(busy), 64'd0);

`ifdef UART_FRAME_CHECKSUM_EN
        // Wrong checksum: error 1, outputs held.
        expect_error(2'd1);
        send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h24);
        drain(10);
`endif

        // Length above MAX_PAYLOAD: error on the cycle after the length byte.
        expect_error(2'd0);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h09);
        @(negedge clk);
        chk("badlen_strobe_timing", 64'(frame_error), 64'd1);
        chk("badlen_busy", 64'(busy), 64'd0);
        drain(5);

        // Inter-byte timeout, then a zero-length frame.
        expect_error(2'd2);
        send_byte(8'hAA); send_byte(8'h01);
        chk("timeout_busy_mid", 64'(busy), 64'd1);
        drain(int'(TMO) + 10);
        chk("timeout_busy_after", 64'(busy), 64'd0);
        send_good(8'h01, 4'd0, 64'd0);
        drain(10);

        // Noise before sync.
        send_byte(8'h00); send_byte(8'hFF);
        chk("noise_not_busy", 64'(busy), 64'd0);
        send_good(8'h07, 4'd0, 64'd0);
        drain(10);

        // Full-length frame at MAX_PAYLOAD.
        send_good(8'h3C, 4'd8, 64'h8877665544332211);
        drain(10);

        // Reset mid-frame: no pulse, outputs cleared.
        send_byte(8'hAA); send_byte(8'h07);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        held_cmd = 8'h00; held_len = 4'd0; held_pl = 64'd0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_cmd", 64'(frame_cmd), 64'd0);
        repeat (5) @(negedge clk);

        // UART error coinciding with a payload byte.
        send_good(8'h22, 4'd1, 64'h5A);
        drain(10);
        expect_error(2'd3);
        send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h55);
        @(posedge clk); #1;
        received = 1'b1; recv_error = 1'b1; rx_byte = 8'h66;
        @(posedge clk); #1;
        received = 1'b0; recv_error = 1'b0;
        @(negedge clk);
        chk("uart_err_busy", 64'(busy), 64'd0);
        drain(5);

        // UART error while idle is ignored; recovery frame works.
        @(posedge clk); #1 recv_error = 1'b1;
        @(posedge clk); #1 recv_error = 1'b0;
        send_good(8'h99, 4'd3, 64'hC0B0A0);
        drain(10);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
